// File: rtl/axis_video_defs.sv
// Shared video-stream definitions: crop FSM encodings and the bit layout of
// packed {tlast, tuser, tdata} stream words.
package axis_video_defs;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } crop_state_e;

    // Sideband bits sit directly above the pixel in a packed stream word.
    function automatic int tuser_bit(input int pixel_width);
        return pixel_width;
    endfunction

    function automatic int tlast_bit(input int pixel_width);
        return pixel_width + 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready output register: upstream may load whenever the
// register is empty or its current word is being taken downstream.
module axis_out_reg #(
    parameter int C_DATA_WIDTH = 10
) (
    input  logic                    f2s_aclk,
    input  logic                    resetn,
    input  logic                    load_valid,
    input  logic [C_DATA_WIDTH-1:0] load_data,
    output logic                    load_ready,
    output logic                    m_valid,
    output logic [C_DATA_WIDTH-1:0] m_data,
    input  logic                    m_ready
);

    assign load_ready = ~m_valid | m_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge f2s_aclk) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load_ready) begin
            m_valid <= load_valid;
            if (load_valid) begin
                m_data <= load_data;
            end
        end
    end

endmodule

// File: rtl/axis_frame_crop.sv
// AXI4-Stream video window extractor: passes only pixels inside a rectangle
// latched at SOF. Optional counters under AXIS_FRAME_CROP_STATS_EN.
module axis_frame_crop
    import axis_video_defs::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                     f2s_aclk,
    input  logic                     resetn,
`ifdef AXIS_FRAME_CROP_STATS_EN
    output logic [15:0]              frame_cnt,
    output logic [15:0]              early_sof_cnt,
`endif
    input  logic [C_IMG_WBITS-1:0]   crop_left,
    input  logic [C_IMG_HBITS-1:0]   crop_top,
    input  logic [C_IMG_WBITS-1:0]   crop_width,
    input  logic [C_IMG_HBITS-1:0]   crop_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int PW     = C_PIXEL_WIDTH;
    localparam int WB     = C_IMG_WBITS;
    localparam int HB     = C_IMG_HBITS;
    localparam int USER_B = tuser_bit(PW);
    localparam int LAST_B = tlast_bit(PW);

    crop_state_e   state, state_nxt;
    logic [WB-1:0] col, left_q, width_q;
    logic [HB-1:0] row, top_q, height_q;

    logic          s_ready, accept, sof_in, in_frame, keep;
    logic [WB-1:0] col_e, left_e, width_e, col_adv;
    logic [HB-1:0] row_e, top_e, height_e, row_adv;
    logic [WB:0]   r_end;
    logic [HB:0]   b_end;
    logic [PW+1:0] load_word, m_word;

    assign s_axis_tready = s_ready;
    assign accept        = s_axis_tvalid & s_ready;
    assign sof_in        = accept & s_axis_tuser;
    assign in_frame      = (state == ACTIVE) | s_axis_tuser;

    // An SOF beat is pixel (0,0) of the new frame and already uses the new config.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        col_e    = col;
        row_e    = row;
        left_e   = left_q;
        top_e    = top_q;
        width_e  = width_q;
        height_e = height_q;
        if (s_axis_tuser) begin
            col_e    = '0;
            row_e    = '0;
            left_e   = crop_left;
            top_e    = crop_top;
            width_e  = crop_width;
            height_e = crop_height;
        end
    end

    assign r_end = {1'b0, left_e} + {1'b0, width_e};
    assign b_end = {1'b0, top_e} + {1'b0, height_e};
    assign keep  = accept & in_frame
                 & (col_e >= left_e) & ({1'b0, col_e} < r_end)
                 & (row_e >= top_e)  & ({1'b0, row_e} < b_end);

    always_comb begin
        load_word            = '0;
        load_word[PW-1:0]    = s_axis_tdata;
        load_word[USER_B]    = (col_e == left_e) & (row_e == top_e);
        load_word[LAST_B]    = ({1'b0, col_e} == r_end - (WB+1)'(1)) | s_axis_tlast;
    end

    // Row saturates so oversized input frames never wrap back into the window.
    always_comb begin
        col_adv = col_e + WB'(1);
        row_adv = row_e;
        if (s_axis_tlast) begin
            col_adv = '0;
            row_adv = (&row_e) ? row_e : row_e + HB'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (sof_in) begin
            state_nxt = ACTIVE;
        end
    end

    always_ff @(posedge f2s_aclk) begin
        if (!resetn) begin
            state    <= WAIT_SOF;
            col      <= '0;
            row      <= '0;
            left_q   <= '0;
            top_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept && in_frame) begin
                col <= col_adv;
                row <= row_adv;
            end
            if (sof_in) begin
                left_q   <= crop_left;
                top_q    <= crop_top;
                width_q  <= crop_width;
                height_q <= crop_height;
            end
        end
    end

    axis_out_reg #(.C_DATA_WIDTH(PW + 2)) u_out_reg (
        .f2s_aclk   (f2s_aclk),
        .resetn     (resetn),
        .load_valid (keep),
        .load_data  (load_word),
        .load_ready (s_ready),
        .m_valid    (m_axis_tvalid),
        .m_data     (m_word),
        .m_ready    (m_axis_tready)
    );

    assign m_axis_tdata = m_word[PW-1:0];
    assign m_axis_tuser = m_word[USER_B];
    assign m_axis_tlast = m_word[LAST_B];

`ifdef AXIS_FRAME_CROP_STATS_EN
    always_ff @(posedge f2s_aclk) begin
        if (!resetn) begin
            frame_cnt     <= '0;
            early_sof_cnt <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tuser) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (sof_in && state == ACTIVE && early_sof_cnt != 16'hFFFF) begin
                early_sof_cnt <= early_sof_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
